// File: rtl/mem_port_arbiter.sv
// Shares the single memory bus port between instruction fetch and data access,
// serving each requester at most once per pipeline step, with a response watchdog.
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        mem_req,
    input  logic [3:0]  mem_web,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic        bus_req,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_web,
    output logic [31:0] bus_wdata,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata,
    output logic [31:0] if_rdata,
    output logic [31:0] mem_rdata,
    output logic        IF_DONE,
    output logic        MEM_DONE,
    output logic        bus_err
);

    typedef enum logic [2:0] {
        IDLE,
        REQ_MEM,
        REQ_IF,
        RSP_MEM,
        RSP_IF
    } state_t;

    localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT_CYC - 1);

    state_t      state_q, state_d;
    logic        if_done_q, if_done_d;
    logic        mem_done_q, mem_done_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] mem_rdata_q, mem_rdata_d;
    logic        bus_err_q, bus_err_d;
    logic [15:0] wdog_q, wdog_d;
    logic        advance;

    assign IF_DONE   = if_done_q | ~if_req;
    assign MEM_DONE  = mem_done_q | ~mem_req;
    assign advance   = IF_DONE & MEM_DONE;
    assign if_rdata  = if_rdata_q;
    assign mem_rdata = mem_rdata_q;
    assign bus_err   = bus_err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
            if_rdata_q  <= 32'd0;
            mem_rdata_q <= 32'd0;
            bus_err_q   <= 1'b0;
            wdog_q      <= 16'd0;
        end else begin
            state_q     <= state_d;
            if_done_q   <= if_done_d;
            mem_done_q  <= mem_done_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
            bus_err_q   <= bus_err_d;
            wdog_q      <= wdog_d;
        end
    end

    // A response whose requester has already dropped its req is completed but discarded.
    always_comb begin
        state_d     = state_q;
        if_done_d   = if_done_q;
        mem_done_d  = mem_done_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        bus_err_d   = bus_err_q;
        wdog_d      = wdog_q;
        bus_req     = 1'b0;
        bus_addr    = 32'd0;
        bus_web     = 4'd0;
        bus_wdata   = 32'd0;

        if (advance) begin
            if_done_d  = 1'b0;
            mem_done_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (!advance && mem_req && !mem_done_q) begin
                    state_d = REQ_MEM;
                end else if (!advance && if_req && !if_done_q) begin
                    state_d = REQ_IF;
                end
            end
            REQ_MEM: begin
                bus_req   = 1'b1;
                bus_addr  = mem_addr;
                bus_web   = mem_web;
                bus_wdata = mem_wdata;
                if (bus_gnt) begin
                    state_d = RSP_MEM;
                    wdog_d  = 16'd0;
                end
            end
            REQ_IF: begin
                bus_req  = 1'b1;
                bus_addr = if_addr;
                if (bus_gnt) begin
                    state_d = RSP_IF;
                    wdog_d  = 16'd0;
                end
            end
            RSP_MEM: begin
                if (bus_rvalid) begin
                    state_d = IDLE;
                    if (mem_req) begin
                        mem_done_d = 1'b1;
                        if (mem_web == 4'd0) begin
                            mem_rdata_d = bus_rdata;
                        end
                    end
                end else if (wdog_q == WDOG_LAST) begin
                    state_d   = IDLE;
                    bus_err_d = 1'b1;
                    if (mem_req) begin
                        mem_done_d  = 1'b1;
                        mem_rdata_d = 32'd0;
                    end
                end else begin
                    wdog_d = wdog_q + 16'd1;
                end
            end
            RSP_IF: begin
                if (bus_rvalid) begin
                    state_d = IDLE;
                    if (if_req) begin
                        if_done_d  = 1'b1;
                        if_rdata_d = bus_rdata;
                    end
                end else if (wdog_q == WDOG_LAST) begin
                    state_d   = IDLE;
                    bus_err_d = 1'b1;
                    if (if_req) begin
                        if_done_d  = 1'b1;
                        if_rdata_d = 32'd0;
                    end
                end else begin
                    wdog_d = wdog_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: the bench plays the memory bus cycle by cycle
// and compares against hand-computed values, with the watchdog shortened to 8 cycles.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        mem_req;
    logic [3:0]  mem_web;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        bus_req;
    logic [31:0] bus_addr;
    logic [3:0]  bus_web;
    logic [31:0] bus_wdata;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;
    logic [31:0] if_rdata;
    logic [31:0] mem_rdata;
    logic        if_done;
    logic        mem_done;
    logic        bus_err;

    int vectors = 0;
    int miscompares = 0;

    mem_port_arbiter #(.TIMEOUT_CYC(8)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr),
        .mem_req(mem_req), .mem_web(mem_web), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .bus_req(bus_req), .bus_addr(bus_addr), .bus_web(bus_web), .bus_wdata(bus_wdata),
        .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
        .if_rdata(if_rdata), .mem_rdata(mem_rdata),
        .IF_DONE(if_done), .MEM_DONE(mem_done), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    // Inputs are changed just after a rising edge and checked 1ns later.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        if_req = 1'b0; if_addr = 32'd0;
        mem_req = 1'b0; mem_web = 4'd0; mem_addr = 32'd0; mem_wdata = 32'd0;
        bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'd0;
    endtask

    task automatic do_reset;
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        vectors++; if (bus_req !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_bus_req: got %b expected 0", bus_req); end
        vectors++; if (bus_addr !== 32'd0) begin miscompares++; $display("[TB] FAIL rst_bus_addr: got %h expected 0", bus_addr); end
        vectors++; if (bus_err !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_bus_err: got %b expected 0", bus_err); end
        vectors++; if (if_rdata !== 32'd0) begin miscompares++; $display("[TB] FAIL rst_if_rdata: got %h expected 0", if_rdata); end
        vectors++; if (mem_rdata !== 32'd0) begin miscompares++; $display("[TB] FAIL rst_mem_rdata: got %h expected 0", mem_rdata); end
        if_req = 1'b1; if_addr = 32'h0000_0200;
        mem_req = 1'b1; mem_addr = 32'h0000_5000;
        #1;
        vectors++; if (if_done !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_if_done: got %b expected 0", if_done); end
        vectors++; if (mem_done !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_mem_done: got %b expected 0", mem_done); end
        rst = 1'b0;
        tick();
        vectors++; if (bus_req !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_req_mem: got %b expected 1", bus_req); end
        bus_gnt = 1'b1;
        tick();
        bus_gnt = 1'b0;
        #1;
        // Asynchronous reset while sitting in RSP_MEM.
        rst = 1'b1;
        #1;
        vectors++; if (bus_req !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_mid_bus_req: got %b expected 0", bus_req); end
        vectors++; if (mem_done !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_mid_mem_done: got %b expected 0", mem_done); end
        vectors++; if (if_done !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_mid_if_done: got %b expected 0", if_done); end
        bus_rvalid = 1'b1; bus_rdata = 32'hFFFF_FFFF;
        tick();
        rst = 1'b0;
        tick();
        vectors++; if (mem_rdata !== 32'd0) begin miscompares++; $display("[TB] FAIL rst_stray_mem_rdata: got %h expected 0", mem_rdata); end
        vectors++; if (if_rdata !== 32'd0) begin miscompares++; $display("[TB] FAIL rst_stray_if_rdata: got %h expected 0", if_rdata); end
        vectors++; if (bus_addr !== 32'h0000_5000) begin miscompares++; $display("[TB] FAIL rst_reissue_addr: got %h expected 00005000", bus_addr); end
        do_reset();
    endtask

    task automatic test_if_fetch;
        if_req = 1'b1; if_addr = 32'h0000_0100;
        #1;
        vectors++; if (mem_done !== 1'b1) begin miscompares++; $display("[TB] FAIL if_mem_done_c0: got %b expected 1", mem_done); end
        vectors++; if (if_done !== 1'b0) begin miscompares++; $display("[TB] FAIL if_done_c0: got %b expected 0", if_done); end
        tick();
        bus_gnt = 1'b1;
        #1;
        vectors++; if (bus_req !== 1'b1) begin miscompares++; $display("[TB] FAIL if_bus_req: got %b expected 1", bus_req); end
        vectors++; if (bus_addr !== 32'h0000_0100) begin miscompares++; $display("[TB] FAIL if_bus_addr: got %h expected 00000100", bus_addr); end
        vectors++; if (bus_web !== 4'd0) begin miscompares++; $display("[TB] FAIL if_bus_web: got %h expected 0", bus_web); end
        tick();
        bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h00A0_0093;
        #1;
        vectors++; if (bus_req !== 1'b0) begin miscompares++; $display("[TB] FAIL if_req_drop: got %b expected 0", bus_req); end
        vectors++; if (if_done !== 1'b0) begin miscompares++; $display("[TB] FAIL if_done_c2: got %b expected 0", if_done); end
        tick();
        bus_rvalid = 1'b0; bus_rdata = 32'd0;
        #1;
        vectors++; if (if_done !== 1'b1) begin miscompares++; $display("[TB] FAIL if_done_c3: got %b expected 1", if_done); end
        vectors++; if (if_rdata !== 32'h00A0_0093) begin miscompares++; $display("[TB] FAIL if_rdata: got %h expected 00a00093", if_rdata); end
        vectors++; if (mem_done !== 1'b1) begin miscompares++; $display("[TB] FAIL if_mem_done_c3: got %b expected 1", mem_done); end
        tick();
        #1;
        vectors++; if (if_done !== 1'b0) begin miscompares++; $display("[TB] FAIL if_flag_clear: got %b expected 0", if_done); end
        vectors++; if (if_rdata !== 32'h00A0_0093) begin miscompares++; $display("[TB] FAIL if_rdata_hold: got %h expected 00a00093", if_rdata); end
        vectors++; if (bus_req !== 1'b0) begin miscompares++; $display("[TB] FAIL if_no_issue_adv: got %b expected 0", bus_req); end
        if_req = 1'b0;
        tick();
    endtask

    task automatic test_store_fetch;
        mem_req = 1'b1; mem_web = 4'hF; mem_addr = 32'h0000_8000; mem_wdata = 32'hDEAD_BEEF;
        if_req = 1'b1; if_addr = 32'h0000_0104;
        tick();
        bus_gnt = 1'b1;
        #1;
        vectors++; if (bus_addr !== 32'h0000_8000) begin miscompares++; $display("[TB] FAIL st_bus_addr: got %h expected 00008000", bus_addr); end
        vectors++; if (bus_web !== 4'hF) begin miscompares++; $display("[TB] FAIL st_bus_web: got %h expected f", bus_web); end
        vectors++; if (bus_wdata !== 32'hDEAD_BEEF) begin miscompares++; $display("[TB] FAIL st_bus_wdata: got %h expected deadbeef", bus_wdata); end
        tick();
        bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h1234_5678;
        tick();
        bus_rvalid = 1'b0; bus_rdata = 32'd0;
        #1;
        vectors++; if (mem_done !== 1'b1) begin miscompares++; $display("[TB] FAIL st_mem_done: got %b expected 1", mem_done); end
        vectors++; if (if_done !== 1'b0) begin miscompares++; $display("[TB] FAIL st_if_pending: got %b expected 0", if_done); end
        vectors++; if (mem_rdata !== 32'd0) begin miscompares++; $display("[TB] FAIL st_mem_rdata: got %h expected 0", mem_rdata); end
        tick();
        bus_gnt = 1'b1;
        #1;
        vectors++; if (bus_addr !== 32'h0000_0104) begin miscompares++; $display("[TB] FAIL st_if_addr: got %h expected 00000104", bus_addr); end
        vectors++; if (bus_web !== 4'd0) begin miscompares++; $display("[TB] FAIL st_if_web: got %h expected 0", bus_web); end
        vectors++; if (bus_wdata !== 32'd0) begin miscompares++; $display("[TB] FAIL st_if_wdata: got %h expected 0", bus_wdata); end
        tick();
        bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h0000_0013;
        #1;
        vectors++; if (mem_done !== 1'b1) begin miscompares++; $display("[TB] FAIL st_mem_done_hold: got %b expected 1", mem_done); end
        tick();
        bus_rvalid = 1'b0; bus_rdata = 32'd0;
        #1;
        vectors++; if ({if_done, mem_done} !== 2'b11) begin miscompares++; $display("[TB] FAIL st_both_done: got %b expected 11", {if_done, mem_done}); end
        vectors++; if (if_rdata !== 32'h0000_0013) begin miscompares++; $display("[TB] FAIL st_if_rdata: got %h expected 00000013", if_rdata); end
        tick();
        #1;
        vectors++; if ({if_done, mem_done} !== 2'b00) begin miscompares++; $display("[TB] FAIL st_single_adv: got %b expected 00", {if_done, mem_done}); end
        clear_inputs();
        tick();
    endtask

    task automatic test_delayed_gnt;
        mem_req = 1'b1; mem_web = 4'd0; mem_addr = 32'h0000_2000; mem_wdata = 32'h0000_0000;
        if_req = 1'b1; if_addr = 32'h0000_0108;
        tick();
        for (int i = 0; i < 5; i++) begin
            bus_gnt = (i == 4);
            #1;
            vectors++; if ({bus_req, bus_addr, bus_web} !== {1'b1, 32'h0000_2000, 4'd0}) begin miscompares++; $display("[TB] FAIL dg_hold_%0d: got req=%b addr=%h web=%h expected req=1 addr=00002000 web=0", i, bus_req, bus_addr, bus_web); end
            tick();
        end
        bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'hCAFE_F00D;
        tick();
        bus_rvalid = 1'b0; bus_rdata = 32'd0;
        #1;
        vectors++; if (mem_rdata !== 32'hCAFE_F00D) begin miscompares++; $display("[TB] FAIL dg_mem_rdata: got %h expected cafef00d", mem_rdata); end
        vectors++; if (bus_req !== 1'b0) begin miscompares++; $display("[TB] FAIL dg_idle_req: got %b expected 0", bus_req); end
        tick();
        #1;
        vectors++; if (bus_addr !== 32'h0000_0108) begin miscompares++; $display("[TB] FAIL dg_no_reissue: got %h expected 00000108", bus_addr); end
        tick();
        bus_gnt = 1'b1;
        #1;
        vectors++; if (bus_addr !== 32'h0000_0108) begin miscompares++; $display("[TB] FAIL dg_if_addr: got %h expected 00000108", bus_addr); end
        tick();
        bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h0000_0033;
        tick();
        bus_rvalid = 1'b0; bus_rdata = 32'd0;
        #1;
        vectors++; if (if_rdata !== 32'h0000_0033) begin miscompares++; $display("[TB] FAIL dg_if_rdata: got %h expected 00000033", if_rdata); end
        vectors++; if (mem_rdata !== 32'hCAFE_F00D) begin miscompares++; $display("[TB] FAIL dg_mem_rdata_hold: got %h expected cafef00d", mem_rdata); end
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_watchdog;
        mem_req = 1'b1; mem_web = 4'd0; mem_addr = 32'h0000_3000;
        tick();
        bus_gnt = 1'b1;
        tick();
        bus_gnt = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            #1;
            vectors++; if ({mem_done, bus_err} !== 2'b00) begin miscompares++; $display("[TB] FAIL wd_wait_%0d: got done/err=%b expected 00", i, {mem_done, bus_err}); end
            tick();
        end
        tick();
        vectors++; if (mem_done !== 1'b1) begin miscompares++; $display("[TB] FAIL wd_mem_done: got %b expected 1", mem_done); end
        vectors++; if (mem_rdata !== 32'd0) begin miscompares++; $display("[TB] FAIL wd_mem_rdata: got %h expected 0", mem_rdata); end
        vectors++; if (bus_err !== 1'b1) begin miscompares++; $display("[TB] FAIL wd_bus_err: got %b expected 1", bus_err); end
        bus_rvalid = 1'b1; bus_rdata = 32'hBAD0_BAD0;
        tick();
        bus_rvalid = 1'b0; bus_rdata = 32'd0;
        #1;
        vectors++; if (mem_rdata !== 32'd0) begin miscompares++; $display("[TB] FAIL wd_late_rvalid: got %h expected 0", mem_rdata); end
        vectors++; if (if_rdata !== 32'h0000_0033) begin miscompares++; $display("[TB] FAIL wd_late_if_rdata: got %h expected 00000033", if_rdata); end
        vectors++; if (mem_done !== 1'b0) begin miscompares++; $display("[TB] FAIL wd_flag_clear: got %b expected 0", mem_done); end
        mem_req = 1'b0;
        tick();
        tick();
        vectors++; if (bus_err !== 1'b1) begin miscompares++; $display("[TB] FAIL wd_err_sticky: got %b expected 1", bus_err); end
        do_reset();
        vectors++; if (bus_err !== 1'b0) begin miscompares++; $display("[TB] FAIL wd_err_rst: got %b expected 0", bus_err); end
    endtask

    task automatic test_timeout_rvalid;
        mem_req = 1'b1; mem_web = 4'd0; mem_addr = 32'h0000_4000;
        tick();
        bus_gnt = 1'b1;
        tick();
        bus_gnt = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            tick();
        end
        bus_rvalid = 1'b1; bus_rdata = 32'h55AA_55AA;
        tick();
        bus_rvalid = 1'b0; bus_rdata = 32'd0;
        #1;
        vectors++; if (mem_done !== 1'b1) begin miscompares++; $display("[TB] FAIL tr_mem_done: got %b expected 1", mem_done); end
        vectors++; if (mem_rdata !== 32'h55AA_55AA) begin miscompares++; $display("[TB] FAIL tr_mem_rdata: got %h expected 55aa55aa", mem_rdata); end
        vectors++; if (bus_err !== 1'b0) begin miscompares++; $display("[TB] FAIL tr_bus_err: got %b expected 0", bus_err); end
        clear_inputs();
        tick();
    endtask

    initial begin
        test_reset();
        test_if_fetch();
        test_store_fetch();
        test_delayed_gnt();
        test_watchdog();
        test_timeout_rvalid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the CPU's single memory bus port between instruction fetch (IF) and data access (MEM).
- Serves at most one transaction per requester per pipeline step.
- Generates IF_DONE and MEM_DONE; the pipeline registers advance only when both are high.
- Holds returned read data stable until the step advances. Includes a response watchdog.

Parameters:
- TIMEOUT_CYC, 255: maximum cycles in a response-wait state before forced completion. Range 1..65535.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- if_req  in  1  IF requests a fetch this step; held until the step advances
- if_addr  in  32  fetch address
- mem_req  in  1  MEM requests a load/store this step; held until the step advances
- mem_web  in  4  byte write strobes; 0 = load
- mem_addr  in  32  data address
- mem_wdata  in  32  store data
- bus_req  out  1  transaction request to memory
- bus_addr  out  32  address of granted requester
- bus_web  out  4  write strobes (0 for IF)
- bus_wdata  out  32  write data (0 for IF)
- bus_gnt  in  1  memory accepts request this cycle
- bus_rvalid  in  1  response (read data or write ack) valid
- bus_rdata  in  32  read data
- if_rdata  out  32  latched fetch data
- mem_rdata  out  32  latched load data
- IF_DONE  out  1  IF side complete for this step
- MEM_DONE  out  1  MEM side complete for this step
- bus_err  out  1  sticky watchdog flag

Behaviour:
- Reset values:
  - FSM = IDLE.
  - bus_req, bus_addr, bus_web, bus_wdata = 0.
  - if_rdata, mem_rdata = 0.
  - Done flags if_done_q, mem_done_q = 0.
  - bus_err = 0; watchdog counter = 0.
- Done outputs (combinational):
  - IF_DONE = if_done_q | ~if_req.
  - MEM_DONE = mem_done_q | ~mem_req.
- Advance: a cycle with IF_DONE & MEM_DONE is an advance. At that clock edge both done flags clear. Requests seen in the following cycle are new.
- FSM states:
  - IDLE:
    - If mem_req & ~mem_done_q and not advancing -> REQ_MEM.
    - Else if if_req & ~if_done_q and not advancing -> REQ_IF.
    - MEM has priority, being the older instruction.
    - bus_rvalid is ignored in IDLE.
  - REQ_MEM / REQ_IF:
    - bus_req = 1; bus_* driven from the owner's inputs.
    - Held stable until bus_gnt. On bus_gnt -> RSP_MEM / RSP_IF.
    - bus_req deasserts the cycle after grant.
  - RSP_MEM / RSP_IF:
    - Wait for bus_rvalid.
    - On rvalid: capture bus_rdata into the owner's rdata register (loads and fetches only; stores leave mem_rdata unchanged). Set the owner's done flag. -> IDLE.
    - The captured data is visible the cycle after rvalid, the same cycle DONE rises.
- Minimum latency with gnt in the same cycle and rvalid the next cycle: REQ to DONE = 3 cycles per transaction. Both requesters = 6 cycles.
- Watchdog:
  - Counter resets on entry to any RSP state and increments each cycle in that state.
  - When it reaches TIMEOUT_CYC without rvalid: owner rdata = 0, owner done = 1, bus_err = 1 (sticky until rst), FSM -> IDLE.
  - A late rvalid arriving in IDLE is ignored.
- Simultaneous events:
  - rvalid and timeout in the same cycle: rvalid wins (real data, no error).
  - Advance and a new request in the same cycle: no issue that cycle; issue from IDLE on the next cycle.
- A requester deasserting its req mid-transaction is illegal. The arbiter completes the transaction anyway and drops the result.
- Reset mid-transaction: asynchronous return to IDLE with all outputs at reset values. The outstanding response is ignored.

Test Plan:
- Reset mid-RSP_MEM: assert rst -> bus_req = 0 and both done flags 0 immediately. Release; stray rvalid in IDLE -> if_rdata and mem_rdata stay 0.
- IF-only fetch:
  - Stimulus: if_req = 1, if_addr = 0x100, mem_req = 0; gnt in the same cycle; rvalid next cycle with rdata = 0x00A00093.
  - Required: MEM_DONE = 1 throughout; IF_DONE rises 3 cycles after req with if_rdata = 0x00A00093; flags clear after the advance.
- Both requesters, store + fetch:
  - Stimulus: mem_web = 4'hF, mem_addr = 0x8000, mem_wdata = 0xDEADBEEF, plus if_req.
  - Required: MEM transaction on the bus first, then IF; mem_rdata unchanged; one advance cycle only after both are done.
- Load with gnt delayed 4 cycles:
  - Required: bus_req, bus_addr and bus_web held stable for all 5 request cycles.
  - Required: mem_rdata = bus_rdata; no re-issue while mem_done_q = 1 and IF is still pending.
- Watchdog with TIMEOUT_CYC = 8 and rvalid never asserted:
  - Required: after 8 RSP cycles, MEM_DONE = 1, mem_rdata = 0, bus_err = 1.
  - Required: a later rvalid is ignored; bus_err stays 1 until rst.
- rvalid on the exact timeout cycle -> data captured, bus_err stays 0.
